// File: rtl/hazard_pkg.sv
// Shared types and constants for the IF/ID/EX hazard controller.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hazard_state_e;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int STATS_W        = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the EX-stage load destination.
// Purely combinational; register 0 never creates a hazard.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] idSrc1,
  input  logic [REG_ADDR_W-1:0] idSrc2,
  input  logic                  idTwoSrc,
  input  logic [REG_ADDR_W-1:0] exDest,
  input  logic                  exMemRead,
  output logic                  loadUse
);

  always_comb begin
    loadUse = exMemRead && (exDest != '0) &&
              ((exDest == idSrc1) || (idTwoSrc && (exDest == idSrc2)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller driving freeze/flush of IF2ID and bubble of ID2EX; Mealy outputs, same-cycle response.
// Optional HAZARD_STATS_EN adds saturating stallCycles/flushEvents counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = REG_ADDR_W_DEF,
  parameter int BRANCH_PENALTY    = 1,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] idSrc1,
  input  logic [REG_ADDR_W-1:0] idSrc2,
  input  logic                  idTwoSrc,
  input  logic [REG_ADDR_W-1:0] exDest,
  input  logic                  exMemRead,
  input  logic                  branchTaken,
  input  logic                  memBusy,
  output logic                  freeze,
  output logic                  flush,
  output logic                  bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [STATS_W-1:0]    stallCycles,
  output logic [STATS_W-1:0]    flushEvents
`endif
);

  localparam int MAX_CNT = (BRANCH_PENALTY > LOAD_STALL_CYCLES) ? BRANCH_PENALTY : LOAD_STALL_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] BR_RELOAD = (BRANCH_PENALTY > 1)    ? CNT_W'(BRANCH_PENALTY - 2)    : '0;
  localparam logic [CNT_W-1:0] LD_RELOAD = (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;

  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             run_rules;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .idSrc1   (idSrc1),
    .idSrc2   (idSrc2),
    .idTwoSrc (idTwoSrc),
    .exDest   (exDest),
    .exMemRead(exMemRead),
    .loadUse  (load_use)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    freeze    = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    run_rules = 1'b0;

    case (state_q)
      RUN: run_rules = 1'b1;
      LOAD_STALL: begin
        if (memBusy) begin
          freeze = 1'b1;
        end else if (branchTaken) begin
          run_rules = 1'b1;
        end else begin
          freeze = 1'b1;
          bubble = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FLUSH: begin
        if (memBusy) begin
          freeze = 1'b1;
        end else begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (branchTaken) begin
            if (BRANCH_PENALTY > 1) cnt_d   = BR_RELOAD;
            else                    state_d = RUN;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (memBusy) freeze    = 1'b1;
        else         run_rules = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Shared by RUN, an abandoned load stall, and the first ready cycle after a memory wait.
    if (run_rules) begin
      state_d = RUN;
      if (memBusy) begin
        freeze  = 1'b1;
        state_d = MEM_WAIT;
      end else if (branchTaken) begin
        flush  = 1'b1;
        bubble = 1'b1;
        if (BRANCH_PENALTY > 1) begin
          state_d = FLUSH;
          cnt_d   = BR_RELOAD;
        end
      end else if (load_use) begin
        freeze = 1'b1;
        bubble = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = LOAD_STALL;
          cnt_d   = LD_RELOAD;
        end
      end
    end

    if (rst) begin
      freeze  = 1'b0;
      flush   = 1'b0;
      bubble  = 1'b0;
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STATS_W-1:0] stall_q, flev_q;
  logic               br_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flev_q  <= '0;
      br_q    <= 1'b0;
    end else begin
      br_q <= branchTaken;
      if (freeze && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (branchTaken && !br_q && !memBusy && (flev_q != '1)) flev_q <= flev_q + 1'b1;
    end
  end

  assign stallCycles = stall_q;
  assign flushEvents = flev_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: a default-parameter DUT and a BRANCH_PENALTY=3 / LOAD_STALL_CYCLES=4 DUT share stimulus.
// Expected {freeze,flush,bubble} triples are queued when driven and compared on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] idSrc1, idSrc2, exDest;
  logic       idTwoSrc, exMemRead, branchTaken, memBusy;
  logic       fz1, fl1, bb1, fz3, fl3, bb3;

  int checks = 0;
  int errors = 0;

  logic [2:0] q1[$];
  logic [2:0] q3[$];
  string      qtag[$];

  localparam logic [2:0] IDLE  = 3'b000;
  localparam logic [2:0] STALL = 3'b101;
  localparam logic [2:0] FLSH  = 3'b011;
  localparam logic [2:0] FRZ   = 3'b100;

  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fe1, sc3, fe3;
`endif

  hazard_ctrl dut1 (
    .clk(clk), .rst(rst), .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc),
    .exDest(exDest), .exMemRead(exMemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .freeze(fz1), .flush(fl1), .bubble(bb1)
`ifdef HAZARD_STATS_EN
    , .stallCycles(sc1), .flushEvents(fe1)
`endif
  );

  hazard_ctrl #(.BRANCH_PENALTY(3), .LOAD_STALL_CYCLES(4)) dut3 (
    .clk(clk), .rst(rst), .idSrc1(idSrc1), .idSrc2(idSrc2), .idTwoSrc(idTwoSrc),
    .exDest(exDest), .exMemRead(exMemRead), .branchTaken(branchTaken), .memBusy(memBusy),
    .freeze(fz3), .flush(fl3), .bubble(bb3)
`ifdef HAZARD_STATS_EN
    , .stallCycles(sc3), .flushEvents(fe3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus: r, load (mr,dest,s1,s2,two), branch, memBusy, expectations for both DUTs.
  task automatic cyc(input string tag, input logic r, input logic mr, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic two,
                     input logic br, input logic mb, input logic [2:0] e1, input logic [2:0] e3);
    @(posedge clk);
    #1;
    rst = r; exMemRead = mr; exDest = d; idSrc1 = s1; idSrc2 = s2; idTwoSrc = two;
    branchTaken = br; memBusy = mb;
    q1.push_back(e1);
    q3.push_back(e3);
    qtag.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [2:0] e1, input logic [2:0] e3);
    cyc(tag, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      logic [2:0] e1, e3;
      string t;
      e1 = q1.pop_front();
      e3 = q3.pop_front();
      t  = qtag.pop_front();
      check_eq({t, "_p1"}, {29'd0, fz1, fl1, bb1}, {29'd0, e1});
      check_eq({t, "_p3"}, {29'd0, fz3, fl3, bb3}, {29'd0, e3});
      check_eq({t, "_excl"}, {31'd0, (fz1 & fl1) | (fz3 & fl3)}, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; exMemRead = 1'b0; exDest = '0; idSrc1 = '0; idSrc2 = '0;
    idTwoSrc = 1'b0; branchTaken = 1'b0; memBusy = 1'b0;

    // reset state
    cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0, IDLE, IDLE);
    cyc("rst1", 1, 0, 0, 0, 0, 0, 0, 0, IDLE, IDLE);
    idle("idle", IDLE, IDLE);

    // load-use on src1, one-cycle hazard
    cyc("lu1", 0, 1, 5, 5, 0, 0, 0, 0, STALL, STALL);
    idle("lu1_a", IDLE, STALL);
    idle("lu1_b", IDLE, STALL);
    idle("lu1_c", IDLE, STALL);
    idle("lu1_d", IDLE, IDLE);

    // register 0 and unused src2 never stall; used src2 does
    cyc("r0", 0, 1, 0, 0, 0, 0, 0, 0, IDLE, IDLE);
    cyc("nosrc2", 0, 1, 7, 3, 7, 0, 0, 0, IDLE, IDLE);
    cyc("src2", 0, 1, 7, 3, 7, 1, 0, 0, STALL, STALL);
    idle("src2_a", IDLE, STALL);
    idle("src2_b", IDLE, STALL);
    idle("src2_c", IDLE, STALL);
    idle("src2_d", IDLE, IDLE);

    // branch penalty
    cyc("br", 0, 0, 0, 0, 0, 0, 1, 0, FLSH, FLSH);
    idle("br_a", IDLE, FLSH);
    idle("br_b", IDLE, FLSH);
    idle("br_c", IDLE, IDLE);

    // branch wins over load-use
    cyc("brlu", 0, 1, 5, 5, 0, 0, 1, 0, FLSH, FLSH);
    idle("brlu_a", IDLE, FLSH);
    idle("brlu_b", IDLE, FLSH);
    idle("brlu_c", IDLE, IDLE);

    // memory wait inside a flush
    cyc("brmw", 0, 0, 0, 0, 0, 0, 1, 0, FLSH, FLSH);
    cyc("brmw_m0", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, FRZ);
    cyc("brmw_m1", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, FRZ);
    idle("brmw_a", IDLE, FLSH);
    idle("brmw_b", IDLE, FLSH);
    idle("brmw_c", IDLE, IDLE);

    // reset in stall cycle 2 aborts the stall
    cyc("rs", 0, 1, 5, 5, 0, 0, 0, 0, STALL, STALL);
    cyc("rs_rst", 1, 1, 5, 5, 0, 0, 0, 0, IDLE, IDLE);
    idle("rs_a", IDLE, IDLE);
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    #1;
    check_eq("stall_cnt1", {16'd0, sc1}, 32'd0);
    check_eq("stall_cnt3", {16'd0, sc3}, 32'd0);
    check_eq("flush_cnt1", {16'd0, fe1}, 32'd0);
    check_eq("flush_cnt3", {16'd0, fe3}, 32'd0);
`endif
    idle("rs_b", IDLE, IDLE);

    // memBusy beats branch in RUN; memory ready with no event returns to idle
    cyc("mbbr", 0, 0, 0, 0, 0, 0, 1, 1, FRZ, FRZ);
    idle("mbbr_a", IDLE, IDLE);

    // branch on the first ready cycle after a memory wait
    cyc("mwbr_m", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, FRZ);
    cyc("mwbr", 0, 0, 0, 0, 0, 0, 1, 0, FLSH, FLSH);
    idle("mwbr_a", IDLE, FLSH);
    idle("mwbr_b", IDLE, FLSH);
    idle("mwbr_c", IDLE, IDLE);

    // branch abandons a load stall
    cyc("lsbr", 0, 1, 5, 5, 0, 0, 0, 0, STALL, STALL);
    cyc("lsbr_b", 0, 0, 0, 0, 0, 0, 1, 0, FLSH, FLSH);
    idle("lsbr_a", IDLE, FLSH);
    idle("lsbr_c", IDLE, FLSH);
    idle("lsbr_d", IDLE, IDLE);

    // memory wait inside a load stall holds the count
    cyc("lsmw", 0, 1, 5, 5, 0, 0, 0, 0, STALL, STALL);
    cyc("lsmw_m", 0, 0, 0, 0, 0, 0, 0, 1, FRZ, FRZ);
    idle("lsmw_a", IDLE, STALL);
    idle("lsmw_b", IDLE, STALL);
    idle("lsmw_c", IDLE, STALL);
    idle("lsmw_d", IDLE, IDLE);

    @(negedge clk);
    #1;
    check_eq("queue_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller that drives the freeze and flush inputs of the IF/ID pipeline register. It also drives the PC-hold and the ID/EX bubble control.
- Detects load-use data hazards between ID and EX.
- Handles taken branches resolved in EX.
- Handles data-memory wait states.
- Sequences multi-cycle stalls and flushes with a small FSM and a down-counter.
- Sits beside the IF2ID/ID2EX registers in the 5-stage core.

Parameters:
REG_ADDR_W, 5, register-file address width
BRANCH_PENALTY, 1, number of cycles flush is held after a taken branch (>=1)
LOAD_STALL_CYCLES, 1, number of cycles freeze is held for a load-use hazard (>=1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; synchronous, active-high
idSrc1  in  REG_ADDR_W  ID-stage source register 1
idSrc2  in  REG_ADDR_W  ID-stage source register 2
idTwoSrc  in  1  ID instruction actually reads idSrc2
exDest  in  REG_ADDR_W  EX-stage destination register
exMemRead  in  1  EX instruction is a load
branchTaken  in  1  EX resolved a taken branch this cycle
memBusy  in  1  data memory not ready; pipeline must hold
freeze  out  1  hold PC and IF2ID
flush  out  1  zero IF2ID contents
bubble  out  1  zero ID2EX control fields

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Registered state and outputs:
  - State and a counter cnt are registered.
  - freeze, flush and bubble are combinational (Mealy) from state, cnt and the inputs.
- Reset:
  - While rst=1, freeze=flush=bubble=0.
  - Next state is RUN, cnt=0.
  - Reset mid-stall or mid-flush aborts the operation immediately.
- Load-use condition:
  - loadUse = exMemRead && exDest!=0 && (exDest==idSrc1 || (idTwoSrc && exDest==idSrc2)).
  - Register 0 never creates a hazard.
- States: RUN, LOAD_STALL, FLUSH, MEM_WAIT. cnt width is clog2(max(BRANCH_PENALTY, LOAD_STALL_CYCLES)).
- Input priority in every state: memBusy > branchTaken > loadUse.
- RUN:
  - memBusy: freeze=1, flush=0, bubble=0; go to MEM_WAIT.
  - else branchTaken: flush=1, bubble=1, freeze=0. If BRANCH_PENALTY>1, go to FLUSH with cnt=BRANCH_PENALTY-2; else stay in RUN.
  - else loadUse: freeze=1, bubble=1, flush=0. If LOAD_STALL_CYCLES>1, go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-2; else stay in RUN.
  - else: all outputs 0.
- LOAD_STALL:
  - Default: freeze=1, bubble=1.
  - If cnt==0, go to RUN; else decrement cnt.
  - memBusy: freeze=1, bubble=0, cnt held, state held.
  - branchTaken (no memBusy): behave as a RUN branch; the stall is abandoned.
- FLUSH:
  - Default: flush=1, bubble=1, freeze=0.
  - If cnt==0, go to RUN; else decrement.
  - memBusy: freeze=1, flush=0, bubble=0, cnt and state held.
  - A new branchTaken reloads cnt=BRANCH_PENALTY-2, or goes to RUN if BRANCH_PENALTY==1.
- MEM_WAIT:
  - While memBusy=1: freeze=1, others 0, stay.
  - On the first cycle with memBusy=0: apply RUN rules combinationally, and take RUN's next-state.
- freeze and flush are never both 1.
- Load-use latency: the stall is visible in the same cycle the hazard is present.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds output ports:
  - stallCycles (16): cycles with freeze=1.
  - flushEvents (16): rising edges of branchTaken accepted, i.e. not masked by memBusy.
- Both counters saturate at 16'hFFFF and reset to 0 on rst.
- When undefined: ports and logic are absent, and the other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - state enum {RUN, LOAD_STALL, FLUSH, MEM_WAIT};
  - REG_ADDR_W default constant;
  - stats counter width 16.
- One sub-module, hazard_detect: purely combinational loadUse compare. The FSM, counter and output decode stay in hazard_ctrl.

Test Plan:
- Load-use: defaults; exMemRead=1, exDest=5, idSrc1=5 for one cycle -> freeze=1, bubble=1 that cycle; all 0 the next cycle once the hazard is removed.
- exMemRead=1, exDest=0, idSrc1=0 -> no stall. Also idTwoSrc=0 with exDest==idSrc2=7 -> no stall.
- Branch penalty: BRANCH_PENALTY=3, branchTaken pulse -> flush=1, bubble=1 for exactly 3 cycles, freeze=0 throughout.
- branchTaken and loadUse in the same cycle -> flush=1, bubble=1, freeze=0.
- Memory wait during flush: BRANCH_PENALTY=3, memBusy=1 for 2 cycles starting at flush cycle 2 -> freeze=1, flush=0 for 2 cycles, then flush=1 for the remaining 2 cycles.
- Reset mid-stall: LOAD_STALL_CYCLES=4, assert rst in stall cycle 2 -> outputs 0 during rst, RUN afterwards. With HAZARD_STATS_EN, counters read 0 after reset.
